// File: rtl/neuron_mac_n.sv
// Time-multiplexed MLP neuron: y = act(sum(a_i*w_i) + b) over N_IN streamed pairs,
// one multiplier, Q(WIDTH-FBITS).FBITS arithmetic, valid/ready on both sides.
module neuron_mac_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FBITS = 24,
    parameter int unsigned N_IN  = 4,
    parameter int unsigned ACT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_w,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             sat
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = PW + $clog2(N_IN + 1) + 1;
    localparam int unsigned CW = $clog2(N_IN + 1);

    localparam logic signed [AW-1:0]    HALF    = AW'(1) << (FBITS - 1);
    localparam logic signed [AW-1:0]    SMAX    = AW'({1'b0, {(WIDTH-1){1'b1}}});
    localparam logic signed [AW-1:0]    SMIN    = ~SMAX;
    localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1) << FBITS;
    localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_NORM,
        S_ACTV,
        S_OUT
    } state_t;

    state_t                  state_q, state_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]        s_q, s_d;
    logic                    satr_q, satr_d;
    logic [WIDTH-1:0]        y_q, y_d;
    logic                    sat_q, sat_d;

    logic signed [PW-1:0]    a_x, w_x;
    logic signed [AW-1:0]    prod_x, bias_x, rnd_sh;
    logic signed [WIDTH-1:0] s_sig, act_y;

    // Full-precision product and bias aligned to the product's 2*FBITS scaling
    assign a_x    = PW'($signed(in_a));
    assign w_x    = PW'($signed(in_w));
    assign prod_x = AW'(a_x * w_x);
    assign bias_x = AW'($signed(in_b)) <<< FBITS;
    assign rnd_sh = (acc_q + HALF) >>> FBITS;
    assign s_sig  = $signed(s_q);

    always_comb begin
        act_y = s_sig;
        if (ACT == 1) begin
            act_y = s_sig[WIDTH-1] ? '0 : s_sig;
        end else if (ACT == 2) begin
            if (s_sig > ONE) begin
                act_y = ONE;
            end else if (s_sig < NEG_ONE) begin
                act_y = NEG_ONE;
            end
        end
    end

    // Next-state and handshake logic; en=0 freezes everything
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        satr_d    = satr_q;
        y_d       = y_q;
        sat_d     = sat_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (en) begin
            unique case (state_q)
                S_IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        acc_d   = bias_x + prod_x;
                        cnt_d   = CW'(1);
                        state_d = (N_IN == 1) ? S_NORM : S_ACC;
                    end
                end
                S_ACC: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        acc_d = acc_q + prod_x;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(N_IN - 1)) begin
                            state_d = S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    if (rnd_sh > SMAX) begin
                        s_d    = WIDTH'(SMAX);
                        satr_d = 1'b1;
                    end else if (rnd_sh < SMIN) begin
                        s_d    = WIDTH'(SMIN);
                        satr_d = 1'b1;
                    end else begin
                        s_d    = WIDTH'(rnd_sh);
                        satr_d = 1'b0;
                    end
                    state_d = S_ACTV;
                end
                S_ACTV: begin
                    y_d     = act_y;
                    sat_d   = satr_q;
                    state_d = S_OUT;
                end
                S_OUT: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            satr_q  <= 1'b0;
            y_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            satr_q  <= satr_d;
            y_q     <= y_d;
            sat_q   <= sat_d;
        end
    end

    assign y   = y_q;
    assign sat = sat_q;

endmodule

// File: tb/tb_neuron_mac_n.sv
// Directed bench for neuron_mac_n: three instances (identity, ReLU, hard-tanh) share stimulus.
module tb_neuron_mac_n;

    localparam int unsigned W = 32;
    typedef logic [W-1:0] vec_t [4];

    logic         clk = 1'b0;
    logic         rst, en, in_valid, out_ready;
    logic [W-1:0] in_a, in_w, in_b;
    logic [2:0]   rdy, ov, st;
    logic [W-1:0] yv [3];
    int           total = 0;
    int           bad   = 0;
    int           xfer  = 0;

    always #5 clk = ~clk;

    neuron_mac_n #(.WIDTH(32), .FBITS(24), .N_IN(4), .ACT(0)) u_id (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_a(in_a), .in_w(in_w), .in_b(in_b), .out_valid(ov[0]), .out_ready(out_ready),
        .y(yv[0]), .sat(st[0]));
    neuron_mac_n #(.WIDTH(32), .FBITS(24), .N_IN(4), .ACT(1)) u_relu (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_a(in_a), .in_w(in_w), .in_b(in_b), .out_valid(ov[1]), .out_ready(out_ready),
        .y(yv[1]), .sat(st[1]));
    neuron_mac_n #(.WIDTH(32), .FBITS(24), .N_IN(4), .ACT(2)) u_ht (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_a(in_a), .in_w(in_w), .in_b(in_b), .out_valid(ov[2]), .out_ready(out_ready),
        .y(yv[2]), .sat(st[2]));

    always @(posedge clk) begin
        if (ov[0] && out_ready) xfer++;
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] w, input logic [W-1:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_w     = w;
        in_b     = b;
        #1;
        while (!rdy[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[0]) chk("beat_timeout", 32'(rdy[0]), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input vec_t a, input vec_t w, input logic [W-1:0] b, input int gap);
        for (int i = 0; i < 4; i++) begin
            beat(a[i], w[i], (i == 0) ? b : 32'h7F00_0000);
            if (i < 3) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_result(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                               input logic [W-1:0] e2, input logic es);
        int lat = 0;
        while (!ov[0] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_y_id"}, yv[0], e0);
        chk({tag, "_y_relu"}, yv[1], e1);
        chk({tag, "_y_ht"}, yv[2], e2);
        chk({tag, "_sat"}, 32'(st), es ? 32'd7 : 32'd0);
    endtask

    task automatic finish_xfer(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_ov_clr"}, 32'(ov), 32'd0);
        chk({tag, "_rdy"}, 32'(rdy), 32'd7);
    endtask

    initial begin
        vec_t a1, w1, w2, a3, w4, ar, wr;
        int   x0, seen;
        a1 = '{4{32'h0100_0000}};
        w1 = '{4{32'h0080_0000}};
        w2 = '{4{32'hFF80_0000}};
        a3 = '{4{32'h7F00_0000}};
        w4 = '{4{32'h8100_0000}};
        ar = '{32'h0000_0001, 32'h0, 32'h0, 32'h0};
        wr = '{4{32'h0080_0000}};

        rst = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_w = '0; in_b = '0;
        @(negedge clk);
        chk("rst_y", yv[0] | yv[1] | yv[2], 32'h0);
        chk("rst_sat", 32'(st), 32'd0);
        chk("rst_ov", 32'(ov), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd7);
        rst = 1'b1;
        @(negedge clk);

        send(a1, w1, 32'h0040_0000, 0);
        wait_result("v1", 32'h0240_0000, 32'h0240_0000, 32'h0100_0000, 1'b0);
        finish_xfer("v1");

        send(a1, w2, 32'h0, 0);
        wait_result("v2", 32'hFE00_0000, 32'h0, 32'hFF00_0000, 1'b0);
        finish_xfer("v2");

        send(a3, a3, 32'h0, 0);
        wait_result("v3", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0100_0000, 1'b1);
        finish_xfer("v3");

        send(a3, w4, 32'h0, 0);
        wait_result("v4", 32'h8000_0000, 32'h0, 32'hFF00_0000, 1'b1);
        finish_xfer("v4");

        send(ar, wr, 32'h0, 0);
        wait_result("rnd", 32'h1, 32'h1, 32'h1, 1'b0);
        finish_xfer("rnd");

        // Reset after beat 2 discards the partial vector
        beat(a1[0], w1[0], 32'h0040_0000);
        beat(a1[1], w1[1], 32'h7F00_0000);
        rst = 1'b0;
        #1;
        chk("mrst_y", yv[0] | yv[1] | yv[2], 32'h0);
        chk("mrst_ov", 32'(ov), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov != 3'b000) seen++;
        end
        chk("mrst_no_ov", 32'(seen), 32'd0);
        chk("mrst_y_hold", yv[0], 32'h0);
        send(a1, w1, 32'h0040_0000, 0);
        wait_result("post_rst", 32'h0240_0000, 32'h0240_0000, 32'h0100_0000, 1'b0);
        finish_xfer("post_rst");

        // Stalls: beat gaps, en=0 mid-ACC and in OUT, out_ready held low
        out_ready = 1'b0;
        beat(a1[0], w1[0], 32'h0040_0000);
        repeat (3) @(negedge clk);
        beat(a1[1], w1[1], 32'h7F00_0000);
        @(negedge clk);
        en = 1'b0; in_valid = 1'b1; in_a = 32'h7F00_0000; in_w = 32'h7F00_0000;
        repeat (4) begin
            #1;
            chk("en0_acc_rdy", 32'(rdy), 32'd0);
            chk("en0_acc_ov", 32'(ov), 32'd0);
            @(negedge clk);
        end
        en = 1'b1; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        beat(a1[2], w1[2], 32'h7F00_0000);
        repeat (3) @(negedge clk);
        beat(a1[3], w1[3], 32'h7F00_0000);
        wait_result("stall", 32'h0240_0000, 32'h0240_0000, 32'h0100_0000, 1'b0);
        x0 = xfer;
        repeat (5) begin
            @(negedge clk);
            chk("hold_y", yv[0], 32'h0240_0000);
            chk("hold_ov", 32'(ov[0]), 32'd1);
        end
        en = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            #1;
            chk("en0_out_rdy", 32'(rdy), 32'd0);
            chk("en0_out_ov", 32'(ov), 32'd0);
            chk("en0_out_y", yv[0], 32'h0240_0000);
            @(negedge clk);
        end
        en = 1'b1;
        #1;
        chk("en1_out_ov", 32'(ov), 32'd7);
        finish_xfer("stall");
        chk("stall_xfer", 32'(xfer - x0), 32'd1);
        chk("stall_y_after", yv[0], 32'h0240_0000);

        repeat (3) @(negedge clk);
        chk("total_xfer", 32'(xfer), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
